// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants, field widths and loader FSM encoding.
// Used by instr_encoder and instr_mem_loader.
package mips_isa_pkg;

  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FUNC_W  = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned WORD_W  = 32;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

  localparam logic [FUNC_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNC_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNC_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNC_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNC_W-1:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/instr_encoder.sv
// Combinational MIPS field encoder: decoded R/I-type fields -> 32-bit word
// plus a legality flag for the supported instruction subset.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic               fmt_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [REG_W-1:0]   rt_i,
  input  logic [REG_W-1:0]   rd_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [FUNC_W-1:0]  func_i,
  input  logic [IMM_W-1:0]   imm_i,
  output logic [WORD_W-1:0]  word_o,
  output logic               legal_o
);

  always_comb begin
    word_o  = '0;
    legal_o = 1'b0;
    if (fmt_i) begin
      word_o = {op_i, rs_i, rt_i, imm_i};
      case (op_i)
        OP_ADDI, OP_LW, OP_SW, OP_SLTI, OP_BEQ: legal_o = 1'b1;
        default:                                legal_o = 1'b0;
      endcase
    end else begin
      word_o = {OP_RTYPE, rs_i, rt_i, rd_i, shamt_i, func_i};
      case (func_i)
        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal_o = 1'b1;
        default:                               legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory writer: clears memory, loads encoded beats, holds the CPU in reset
// until the image is complete. Optional LOADER_CHECKSUM_EN adds a running XOR checksum_o.
module instr_mem_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned INSTR_NUM = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              fmt_i,
  input  logic [5:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [5:0]        func_i,
  input  logic [15:0]       imm_i,
  input  logic              last_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       checksum_o,
`endif
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(INSTR_NUM);

  loader_state_e     state_q;
  logic              in_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_data_q;
  logic              cpu_rst_n_q;
  logic              done_q;
  logic              err_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   clr_idx_q;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q;
`endif

  logic [31:0] enc_word;
  logic        enc_legal;

  instr_encoder u_enc (
    .fmt_i   (fmt_i),
    .op_i    (op_i),
    .rs_i    (rs_i),
    .rt_i    (rt_i),
    .rd_i    (rd_i),
    .shamt_i (shamt_i),
    .func_i  (func_i),
    .imm_i   (imm_i),
    .word_o  (enc_word),
    .legal_o (enc_legal)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
      clr_idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q  <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (state_q == ST_DONE) cpu_rst_n_q <= 1'b1;
          // Entering CLEAR issues the index-0 zero write on the same edge.
          if (start_i) begin
            state_q     <= ST_CLEAR;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            clr_idx_q   <= (ADDR_W+1)'(1);
            count_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q  <= '0;
`endif
          end
        end
        ST_CLEAR: begin
          if (clr_idx_q == CAP) begin
            state_q    <= ST_LOAD;
            in_ready_q <= 1'b1;
            mem_addr_q <= '0;
          end else begin
            mem_we_q   <= 1'b1;
            mem_addr_q <= clr_idx_q[ADDR_W-1:0];
            clr_idx_q  <= clr_idx_q + 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid_i && in_ready_q) begin
            if (!enc_legal || count_q == CAP) begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= count_q[ADDR_W-1:0];
              mem_data_q <= enc_word;
              count_q    <= count_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
              checksum_q <= checksum_q ^ enc_word;
`endif
              if (last_i) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign count_o     = count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_o  = checksum_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader; checksum checks under LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        fmt_i;
  logic [5:0]  op_i;
  logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
  logic [5:0]  func_i;
  logic [15:0] imm_i;
  logic        last_i;
  logic        mem_we_o;
  logic [7:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic        cpu_rst_n_o;
  logic        done_o;
  logic        err_o;
  logic [8:0]  count_o;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  instr_mem_loader #(.INSTR_NUM(256), .ADDR_W(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .fmt_i       (fmt_i),
    .op_i        (op_i),
    .rs_i        (rs_i),
    .rt_i        (rt_i),
    .rd_i        (rd_i),
    .shamt_i     (shamt_i),
    .func_i      (func_i),
    .imm_i       (imm_i),
    .last_i      (last_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .done_o      (done_o),
    .err_o       (err_o),
`ifdef LOADER_CHECKSUM_EN
    .checksum_o  (checksum_o),
`endif
    .count_o     (count_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_itype(input logic [5:0] op, input logic [15:0] imm, input logic last);
    fmt_i = 1'b1; op_i = op; rs_i = 5'd0; rt_i = 5'd1; imm_i = imm; last_i = last;
    rd_i = 5'd31; shamt_i = 5'd31; func_i = 6'h3F;
  endtask

  task automatic set_rtype(input logic [5:0] func, input logic last);
    fmt_i = 1'b0; op_i = 6'h3F; rs_i = 5'd1; rt_i = 5'd1; rd_i = 5'd2; shamt_i = 5'd0;
    func_i = func; imm_i = 16'hFFFF; last_i = last;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(in_ready_o), 32'd0);
    check({tag, "_we"},    32'(mem_we_o), 32'd0);
    check({tag, "_addr"},  32'(mem_addr_o), 32'd0);
    check({tag, "_data"},  mem_data_o, 32'd0);
    check({tag, "_cpurst"}, 32'(cpu_rst_n_o), 32'd0);
    check({tag, "_done"},  32'(done_o), 32'd0);
    check({tag, "_err"},   32'(err_o), 32'd0);
    check({tag, "_count"}, 32'(count_o), 32'd0);
  endtask

  // Pulses start and walks the 256 clear cycles, ending in LOAD.
  task automatic run_clear(input string tag);
    int bad = 0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, "_cnt_clr"}, 32'(count_o), 32'd0);
    check({tag, "_err_clr"}, 32'(err_o), 32'd0);
    for (int i = 0; i < 256; i++) begin
      if (!(mem_we_o === 1'b1 && mem_addr_o === 8'(i) && mem_data_o === 32'd0 &&
            in_ready_o === 1'b0 && cpu_rst_n_o === 1'b0))
        bad++;
      tick();
    end
    check({tag, "_clr_bad"}, 32'(bad), 32'd0);
    check({tag, "_clr_we_end"}, 32'(mem_we_o), 32'd0);
    check({tag, "_clr_ready"}, 32'(in_ready_o), 32'd1);
  endtask

  initial begin
    int bad, nwr, wrap, nexp;
    logic vld;
    rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; last_i = 1'b0;
    set_itype(6'h08, 16'h0, 1'b0);
    tick(); tick();
    check_reset_vals("rst");
    rst_i = 1'b1;
    tick();
    check("idle_ready", 32'(in_ready_o), 32'd0);

    // Test 1: clear pass
    run_clear("t1");

    // Test 2: ADDI then ADD(last)
    set_itype(6'h08, 16'h0005, 1'b0);
    in_valid_i = 1'b1;
    tick();
    check("t2_we0",   32'(mem_we_o), 32'd1);
    check("t2_addr0", 32'(mem_addr_o), 32'd0);
    check("t2_data0", mem_data_o, 32'h20010005);
    check("t2_cnt1",  32'(count_o), 32'd1);
    set_rtype(6'h20, 1'b1);
    tick();
    in_valid_i = 1'b0;
    check("t2_we1",   32'(mem_we_o), 32'd1);
    check("t2_addr1", 32'(mem_addr_o), 32'd1);
    check("t2_data1", mem_data_o, 32'h00211020);
    check("t2_cnt2",  32'(count_o), 32'd2);
    check("t2_done",  32'(done_o), 32'd1);
    check("t2_cpurst_lo", 32'(cpu_rst_n_o), 32'd0);
    check("t2_ready_lo",  32'(in_ready_o), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("t6_checksum", checksum_o, 32'h20201025);
`endif
    in_valid_i = 1'b1;
    tick();
    check("t2_cpurst_hi", 32'(cpu_rst_n_o), 32'd1);
    check("t2_done_we",   32'(mem_we_o), 32'd0);
    in_valid_i = 1'b0;

    // Test 3: illegal I-type opcode
    run_clear("t3");
    check("t3_cpurst_lo", 32'(cpu_rst_n_o), 32'd0);
    check("t3_done_clr",  32'(done_o), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    check("t3_checksum_clr", checksum_o, 32'd0);
`endif
    set_itype(6'h3F, 16'h1234, 1'b0);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("t3_err",    32'(err_o), 32'd1);
    check("t3_we",     32'(mem_we_o), 32'd0);
    check("t3_ready",  32'(in_ready_o), 32'd0);
    check("t3_count",  32'(count_o), 32'd0);
    tick();
    check("t3_cpurst", 32'(cpu_rst_n_o), 32'd0);

    // Test 3b: illegal R-type funct 21
    run_clear("t3b");
    set_rtype(6'h21, 1'b1);
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("t3b_err",  32'(err_o), 32'd1);
    check("t3b_we",   32'(mem_we_o), 32'd0);
    check("t3b_done", 32'(done_o), 32'd0);

    // Test 4: 257 beats, overflow on the last
    run_clear("t4");
    bad = 0; nwr = 0; wrap = 0;
    set_itype(6'h08, 16'd0, 1'b0);
    in_valid_i = 1'b1;
    for (int k = 0; k < 257; k++) begin
      tick();
      if (mem_we_o === 1'b1) nwr++;
      if (k < 256) begin
        if (!(mem_we_o === 1'b1 && mem_addr_o === 8'(k) &&
              mem_data_o === (32'h20010000 | 32'(k))))
          bad++;
        if (k > 0 && mem_addr_o === 8'd0) wrap++;
      end
      imm_i = 16'(k + 1);
    end
    in_valid_i = 1'b0;
    check("t4_bad",   32'(bad), 32'd0);
    check("t4_nwr",   32'(nwr), 32'd256);
    check("t4_wrap",  32'(wrap), 32'd0);
    check("t4_err",   32'(err_o), 32'd1);
    check("t4_count", 32'(count_o), 32'd256);
    check("t4_addr",  32'(mem_addr_o), 32'd255);

    // Test 5: start ignored in LOAD, toggled valid, then async reset
    run_clear("t5");
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t5_start_ign_ready", 32'(in_ready_o), 32'd1);
    check("t5_start_ign_we",    32'(mem_we_o), 32'd0);
    bad = 0; nexp = 0;
    for (int c = 0; c < 8; c++) begin
      vld = (c % 2 == 0);
      in_valid_i = vld;
      set_itype(6'h23, 16'(c), 1'b0);
      tick();
      if (vld) begin
        if (!(mem_we_o === 1'b1 && mem_addr_o === 8'(nexp) &&
              mem_data_o === (32'h8C010000 | 32'(c))))
          bad++;
        nexp++;
      end else if (mem_we_o !== 1'b0) begin
        bad++;
      end
    end
    in_valid_i = 1'b0;
    check("t5_toggle_bad", 32'(bad), 32'd0);
    check("t5_count",      32'(count_o), 32'd4);
    #2 rst_i = 1'b0;
    #1 check_reset_vals("t5_async");
    @(negedge clk_i);
    rst_i = 1'b1;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    check("t5_idle_ready", 32'(in_ready_o), 32'd0);
    check("t5_idle_we",    32'(mem_we_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
